// File: rtl/pipe_ctrl_if.sv
// Hazard-source / pipeline-control bundle for pipe_ctrl.
// Perf counter outputs exist only when PIPE_CTRL_PERF_CNT_EN is defined.
interface pipe_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  jump_req_i;
    logic [ADDR_WIDTH-1:0] jump_addr_i;
    logic                  trap_req_i;
    logic [ADDR_WIDTH-1:0] trap_vec_i;
    logic                  hazard_stall_i;
    logic                  mc_busy_i;
    logic                  pc_redirect_o;
    logic [ADDR_WIDTH-1:0] pc_redirect_addr_o;
    logic                  pc_hold_o;
    logic                  if_id_hold_o;
    logic                  pipeline_flush_o;
    logic                  id_ex_flush_o;
    logic                  stall_timeout_o;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0]           flush_cycles_o;
    logic [31:0]           stall_cycles_o;
`endif

    modport master (
        output jump_req_i, jump_addr_i, trap_req_i, trap_vec_i, hazard_stall_i, mc_busy_i,
        input  pc_redirect_o, pc_redirect_addr_o, pc_hold_o, if_id_hold_o,
               pipeline_flush_o, id_ex_flush_o, stall_timeout_o
`ifdef PIPE_CTRL_PERF_CNT_EN
        , input flush_cycles_o, stall_cycles_o
`endif
    );

    modport slave (
        input  jump_req_i, jump_addr_i, trap_req_i, trap_vec_i, hazard_stall_i, mc_busy_i,
        output pc_redirect_o, pc_redirect_addr_o, pc_hold_o, if_id_hold_o,
               pipeline_flush_o, id_ex_flush_o, stall_timeout_o
`ifdef PIPE_CTRL_PERF_CNT_EN
        , output flush_cycles_o, stall_cycles_o
`endif
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: PC redirect + timed flush, zero-latency holds, stall watchdog.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl #(
    parameter int unsigned            ADDR_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0]  RST_ADDR      = '0,
    parameter int unsigned            FLUSH_CYCLES  = 2,
    parameter int unsigned            STALL_TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned WD_W  = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_MAX     = WD_W'(STALL_TIMEOUT);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
    logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  redirect_q, redirect_d;
    logic                  timeout_q, timeout_d;
    logic                  hold;

    // Next-state, redirect latch and watchdog; trap outranks jump, and FLUSH ignores wrong-path requests
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        addr_d      = addr_q;
        redirect_d  = 1'b0;
        hold        = 1'b0;
        wd_cnt_d    = wd_cnt_q;
        case (state_q)
            RUN: begin
                if (bus.trap_req_i) begin
                    addr_d      = bus.trap_vec_i;
                    flush_cnt_d = FLUSH_LOAD;
                    redirect_d  = 1'b1;
                    state_d     = FLUSH;
                end else if (bus.jump_req_i) begin
                    addr_d      = bus.jump_addr_i;
                    flush_cnt_d = FLUSH_LOAD;
                    redirect_d  = 1'b1;
                    state_d     = FLUSH;
                end else begin
                    hold = bus.hazard_stall_i | bus.mc_busy_i;
                end
            end
            FLUSH: begin
                if (bus.trap_req_i) begin
                    addr_d      = bus.trap_vec_i;
                    flush_cnt_d = FLUSH_LOAD;
                    redirect_d  = 1'b1;
                end else if (flush_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
        endcase
        if (rst) hold = 1'b0;
        if (!bus.mc_busy_i || redirect_d) begin
            wd_cnt_d = '0;
        end else if (state_q == RUN && wd_cnt_q != WD_MAX) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
        timeout_d = timeout_q | (wd_cnt_d == WD_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            wd_cnt_q    <= '0;
            addr_q      <= RST_ADDR;
            redirect_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            addr_q      <= addr_d;
            redirect_q  <= redirect_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.pc_redirect_o      = redirect_q;
    assign bus.pc_redirect_addr_o = addr_q;
    assign bus.pipeline_flush_o   = (state_q == FLUSH);
    assign bus.pc_hold_o          = hold;
    assign bus.if_id_hold_o       = hold;
    assign bus.id_ex_flush_o      = ((state_q == FLUSH) | hold) & ~rst;
    assign bus.stall_timeout_o    = timeout_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] flush_cycles_q, stall_cycles_q;

    // Free-running event counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cycles_q <= '0;
            stall_cycles_q <= '0;
        end else begin
            flush_cycles_q <= flush_cycles_q + 32'(state_q == FLUSH);
            stall_cycles_q <= stall_cycles_q + 32'(hold);
        end
    end

    assign bus.flush_cycles_o = flush_cycles_q;
    assign bus.stall_cycles_o = stall_cycles_q;
`endif
endmodule
